branch_predictor: RTL and testbench

- Dynamic branch predictor for the pipelined RV64 core. It is the producer side of the branch decision path.
- IF stage looks up a predicted direction by PC. ID stage resolves the real direction with the equality comparator and writes the outcome back here.
- Holds a Branch History Table (BHT) of 2-bit saturating counters. It also raises a registered mispredict/flush pulse when the resolved outcome disagrees with the prediction that travelled down the pipe.

---
 rtl/branch_predictor.sv | 85 ++++++++
 tb/tb_branch_predictor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: BHT of 2-bit saturating counters with a registered mispredict pulse.
// Optional BP_STATS_EN macro adds branch and mispredict event counters.
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         PC_WIDTH   = 64,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic                upd_pred_taken,
  input  logic                stall,
`ifdef BP_STATS_EN
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts,
`endif
  output logic                mispredict,
  output logic                correct_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            bht [ENTRIES];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  accept;
  logic                  wrong;

  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
  assign upd_idx    = upd_pc[INDEX_BITS+1:2];

  // Aliasing is intentional: the byte offset and bits above the index never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                            upd_pc[PC_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

  // Read before write: a same-cycle update to this entry is seen from the next cycle.
  assign pred_taken = bht[lookup_idx][1];

  assign accept = upd_valid & ~stall;
  assign wrong  = accept & (upd_taken ^ upd_pred_taken);

  // NOTE: the table is flop-based and every entry must come out of reset as INIT_STATE,
  // so the whole array sits in the async reset branch; it cannot map onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= INIT_STATE;
      end
    end else if (accept) begin
      if (upd_taken) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict    <= 1'b0;
      correct_taken <= 1'b0;
    end else begin
      mispredict <= wrong;
      if (wrong) correct_taken <= upd_taken;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept) stat_branches    <= stat_branches + 32'd1;
      if (wrong)  stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed literal checks plus randomized traffic
// compared every cycle against a behavioural table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] lookup_pc = '0;
  logic        pred_taken;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred_taken = 1'b0;
  logic        stall = 1'b0;
  logic        mispredict;
  logic        correct_taken;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_pred_taken (upd_pred_taken),
    .stall          (stall),
`ifdef BP_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .mispredict     (mispredict),
    .correct_taken  (correct_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counter per table slot, clamped to 0..3.
  int          m_bht [64];
  bit          m_misp;
  bit          m_ct;
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic int slot(input logic [63:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_pred(input logic [63:0] pc);
    return m_bht[slot(pc)] >= 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_bht[i] <= 1;
      m_misp <= 1'b0;
      m_ct   <= 1'b0;
      m_br   <= '0;
      m_mp   <= '0;
    end else begin
      if (upd_valid && !stall) begin
        if (upd_taken) m_bht[slot(upd_pc)] <= (m_bht[slot(upd_pc)] == 3) ? 3 : m_bht[slot(upd_pc)] + 1;
        else           m_bht[slot(upd_pc)] <= (m_bht[slot(upd_pc)] == 0) ? 0 : m_bht[slot(upd_pc)] - 1;
        m_br <= m_br + 1;
        if (upd_taken != upd_pred_taken) begin
          m_ct <= upd_taken;
          m_mp <= m_mp + 1;
        end
      end
      m_misp <= upd_valid && !stall && (upd_taken != upd_pred_taken);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pred_taken", 32'(pred_taken), 32'(m_pred(lookup_pc)));
      check("cyc_mispredict", 32'(mispredict), 32'(m_misp));
      check("cyc_correct_taken", 32'(correct_taken), 32'(m_ct));
`ifdef BP_STATS_EN
      check("cyc_stat_branches", stat_branches, m_br);
      check("cyc_stat_mispredicts", stat_mispredicts, m_mp);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [63:0] pc, input logic t, input logic pt, input logic st);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = t;
    upd_pred_taken = pt;
    stall          = st;
  endtask

  initial begin
    logic [63:0] sample_pcs [8];
    bit          exp_up [4];
    sample_pcs = '{64'h0000, 64'h1000, 64'h2044, 64'h0008, 64'hFFF0, 64'h1234_5678_9ABC_DEF0,
                   64'h007C, 64'h0203};
    exp_up = '{1'b1, 1'b1, 1'b1, 1'b1};

    #12 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state: every sampled slot weakly not-taken, outputs low.
    lookup_pc = 64'h1000;
    #1 check("reset_pred_0x1000", 32'(pred_taken), 32'd0);
    check("reset_mispredict", 32'(mispredict), 32'd0);
    check("reset_correct_taken", 32'(correct_taken), 32'd0);
    for (int i = 0; i < 8; i++) begin
      lookup_pc = sample_pcs[i];
      #1 check($sformatf("reset_pred_sample%0d", i), 32'(pred_taken), 32'd0);
    end

    // Saturation up then walk back down.
    lookup_pc = 64'h1000;
    set_upd(64'h1000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("sat_up_%0d", i + 1), 32'(pred_taken), 32'(exp_up[i]));
    end
    set_upd(64'h1000, 1'b0, 1'b1, 1'b0);
    step();
    check("sat_down_1", 32'(pred_taken), 32'd1);
    step();
    check("sat_down_2", 32'(pred_taken), 32'd0);
    upd_valid = 1'b0;

    // Mispredict pulse and correct_taken hold.
    set_upd(64'h3004, 1'b1, 1'b0, 1'b0);
    step();
    check("misp_pulse", 32'(mispredict), 32'd1);
    check("misp_correct_taken", 32'(correct_taken), 32'd1);
    upd_valid = 1'b0;
    step();
    check("misp_clear", 32'(mispredict), 32'd0);
    check("misp_ct_hold", 32'(correct_taken), 32'd1);

    // Same-slot lookup and update: old value this cycle, new value next cycle.
    lookup_pc = 64'h2040;
    set_upd(64'h2040, 1'b1, 1'b0, 1'b0);
    #1 check("collide_same_cycle", 32'(pred_taken), 32'd0);
    step();
    check("collide_next_cycle", 32'(pred_taken), 32'd1);
    upd_valid = 1'b0;

    // Stalled update is dropped and suppresses the pulse.
    set_upd(64'h2040, 1'b0, 1'b1, 1'b1);
    step();
    check("stall_no_misp", 32'(mispredict), 32'd0);
    check("stall_entry_kept", 32'(pred_taken), 32'd1);
    stall = 1'b0;
    upd_valid = 1'b0;

    // Aliasing: 0x0100 and 0x0200 share slot 0.
    set_upd(64'h0100, 1'b1, 1'b1, 1'b0);
    step();
    upd_valid = 1'b0;
    lookup_pc = 64'h0200;
    #1 check("alias_pred", 32'(pred_taken), 32'd1);

    // Async reset while a pulse is live.
    set_upd(64'h3004, 1'b1, 1'b0, 1'b0);
    step();
    upd_valid = 1'b0;
    check("pre_reset_misp", 32'(mispredict), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_misp_drop", 32'(mispredict), 32'd0);
    check("async_ct_drop", 32'(correct_taken), 32'd0);
    check("async_alias_slot", 32'(pred_taken), 32'd0);
    lookup_pc = 64'h2040;
    #1 check("async_0x2040_slot", 32'(pred_taken), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

`ifdef BP_STATS_EN
    // Five accepted updates, two wrong, plus a stalled one that must not count.
    check("stats_reset_br", stat_branches, 32'd0);
    check("stats_reset_mp", stat_mispredicts, 32'd0);
    set_upd(64'h0010, 1'b1, 1'b1, 1'b0); step();
    set_upd(64'h0014, 1'b0, 1'b1, 1'b0); step();
    set_upd(64'h0018, 1'b0, 1'b1, 1'b1); step();
    set_upd(64'h0018, 1'b0, 1'b0, 1'b0); step();
    set_upd(64'h001C, 1'b1, 1'b0, 1'b0); step();
    set_upd(64'h0020, 1'b1, 1'b1, 1'b0); step();
    upd_valid = 1'b0;
    stall = 1'b0;
    check("stats_branches", stat_branches, 32'd5);
    check("stats_mispredicts", stat_mispredicts, 32'd2);
`endif

    // Randomized traffic over a few hot slots so counters hit both rails.
    for (int c = 0; c < 3000; c++) begin
      step();
      upd_valid      = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 4) == 0);
      upd_taken      = $urandom_range(0, 2) != 0;
      upd_pred_taken = $urandom_range(0, 1) == 1;
      upd_pc         = {$urandom, $urandom};
      upd_pc[7:2]    = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) lookup_pc = upd_pc;
      else begin
        lookup_pc      = {$urandom, $urandom};
        lookup_pc[7:2] = 6'($urandom_range(0, 7));
      end
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
